fill_sequencer: RTL and testbench

- Controller that sequences the fill engine for one rectangle-fill command.
- Accepts a command (corners, colour, layer) over a valid/ready handshake and normalises the corners.
- Issues math_start, then one row_start per scanline and one fill_start per 64-pixel chunk, waiting for fill_done after each chunk.
- Sits between the command decoder and the fill engine/SRAM path; signals all_finish when the rectangle is complete.

---
 rtl/fill_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_fill_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fill_sequencer.sv
// Rectangle-fill sequencer: normalises a command's corners, then steps the fill
// engine through every scanline in CHUNK_PIX-wide bursts, waiting for fill_done after each.
module fill_sequencer #(
    parameter int FB_WIDTH    = 640,
    parameter int CHUNK_PIX   = 64,
    parameter int MATH_CYCLES = 4,
    parameter int ROW_CYCLES  = 3,
    parameter int TIMEOUT     = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [47:0] coordinates,
    input  logic [23:0] color_code,
    input  logic        layer_num,
    output logic        math_start,
    output logic        row_start,
    output logic        fill_start,
    input  logic        fill_done,
    output logic [11:0] cur_row,
    output logic [11:0] chunk_x,
    output logic [6:0]  chunk_len,
    output logic [23:0] chunk_addr,
    output logic [23:0] color_out,
    output logic        layer_out,
    output logic        busy,
    output logic        all_finish,
    output logic        error
);

    localparam int CNT_MAX = (TIMEOUT > MATH_CYCLES) ?
                             ((TIMEOUT > ROW_CYCLES) ? TIMEOUT : ROW_CYCLES) :
                             ((MATH_CYCLES > ROW_CYCLES) ? MATH_CYCLES : ROW_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MATH,
        S_ROW,
        S_FILL,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [11:0]        xl_q, xl_d, xh_q, xh_d, yl_q, yl_d, yh_q, yh_d;
    logic [23:0]        color_q, color_d;
    logic               layer_q, layer_d;
    logic [11:0]        cur_row_q, cur_row_d;
    logic [11:0]        chunk_x_q, chunk_x_d;
    logic [6:0]         chunk_len_q, chunk_len_d;
    logic [23:0]        chunk_addr_q, chunk_addr_d;
    logic               error_q, error_d;

    logic [11:0]        x0, y0, x1, y1;
    logic [12:0]        chunk_end;

    assign x0 = coordinates[47:36];
    assign y0 = coordinates[35:24];
    assign x1 = coordinates[23:12];
    assign y1 = coordinates[11:0];

    // One past the last pixel of the current chunk, kept 13 bits so x=4095 cannot wrap.
    assign chunk_end = {1'b0, chunk_x_q} + {6'b0, chunk_len_q};

    function automatic logic [6:0] calc_len(input logic [11:0] x, input logic [11:0] x_hi);
        logic [12:0] rem;
        rem = {1'b0, x_hi} - {1'b0, x} + 13'd1;
        if (rem > 13'(CHUNK_PIX)) begin
            return 7'(CHUNK_PIX);
        end
        return rem[6:0];
    endfunction

    function automatic logic [22:0] calc_addr(input logic [11:0] row, input logic [11:0] x);
        return 23'(row) * 23'(FB_WIDTH) + 23'(x);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            xl_q         <= '0;
            xh_q         <= '0;
            yl_q         <= '0;
            yh_q         <= '0;
            color_q      <= '0;
            layer_q      <= 1'b0;
            cur_row_q    <= '0;
            chunk_x_q    <= '0;
            chunk_len_q  <= '0;
            chunk_addr_q <= '0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            xl_q         <= xl_d;
            xh_q         <= xh_d;
            yl_q         <= yl_d;
            yh_q         <= yh_d;
            color_q      <= color_d;
            layer_q      <= layer_d;
            cur_row_q    <= cur_row_d;
            chunk_x_q    <= chunk_x_d;
            chunk_len_q  <= chunk_len_d;
            chunk_addr_q <= chunk_addr_d;
            error_q      <= error_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        xl_d         = xl_q;
        xh_d         = xh_q;
        yl_d         = yl_q;
        yh_d         = yh_q;
        color_d      = color_q;
        layer_d      = layer_q;
        cur_row_d    = cur_row_q;
        chunk_x_d    = chunk_x_q;
        chunk_len_d  = chunk_len_q;
        chunk_addr_d = chunk_addr_q;
        error_d      = error_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    xl_d    = (x0 < x1) ? x0 : x1;
                    xh_d    = (x0 < x1) ? x1 : x0;
                    yl_d    = (y0 < y1) ? y0 : y1;
                    yh_d    = (y0 < y1) ? y1 : y0;
                    color_d = color_code;
                    layer_d = layer_num;
                    error_d = 1'b0;
                    cnt_d   = '0;
                    state_d = S_MATH;
                end
            end
            S_MATH: begin
                if (cnt_q == CNT_W'(MATH_CYCLES)) begin
                    cnt_d     = '0;
                    cur_row_d = yl_q;
                    state_d   = S_ROW;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ROW: begin
                if (cnt_q == CNT_W'(ROW_CYCLES)) begin
                    cnt_d     = '0;
                    chunk_x_d = xl_q;
                    state_d   = S_FILL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FILL: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (fill_done) begin
                    cnt_d = '0;
                    if (chunk_end <= {1'b0, xh_q}) begin
                        chunk_x_d = chunk_x_q + 12'(CHUNK_PIX);
                        state_d   = S_FILL;
                    end else if (cur_row_q < yh_q) begin
                        cur_row_d = cur_row_q + 12'd1;
                        state_d   = S_ROW;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Chunk outputs are registered on entry to FILL so they hold steady through WAIT.
        if (state_d == S_FILL) begin
            chunk_len_d  = calc_len(chunk_x_d, xh_q);
            chunk_addr_d = {layer_q, calc_addr(cur_row_d, chunk_x_d)};
        end
    end

    always_comb begin
        cmd_ready  = (state_q == S_IDLE);
        busy       = (state_q != S_IDLE);
        math_start = (state_q == S_MATH) && (cnt_q == '0);
        row_start  = (state_q == S_ROW) && (cnt_q == '0);
        fill_start = (state_q == S_FILL);
        all_finish = (state_q == S_DONE);
    end

    assign cur_row    = cur_row_q;
    assign chunk_x    = chunk_x_q;
    assign chunk_len  = chunk_len_q;
    assign chunk_addr = chunk_addr_q;
    assign color_out  = color_q;
    assign layer_out  = layer_q;
    assign error      = error_q;

endmodule

// File: tb/tb_fill_sequencer.sv
// Directed bench for fill_sequencer: a vector table of rectangle commands with
// hand-computed chunk lists, plus reset-abort and held-valid handshake sequences.
module tb_fill_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [47:0] coordinates;
    logic [23:0] color_code;
    logic        layer_num;
    logic        math_start;
    logic        row_start;
    logic        fill_start;
    logic        fill_done;
    logic [11:0] cur_row;
    logic [11:0] chunk_x;
    logic [6:0]  chunk_len;
    logic [23:0] chunk_addr;
    logic [23:0] color_out;
    logic        layer_out;
    logic        busy;
    logic        all_finish;
    logic        error;

    fill_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .coordinates (coordinates),
        .color_code  (color_code),
        .layer_num   (layer_num),
        .math_start  (math_start),
        .row_start   (row_start),
        .fill_start  (fill_start),
        .fill_done   (fill_done),
        .cur_row     (cur_row),
        .chunk_x     (chunk_x),
        .chunk_len   (chunk_len),
        .chunk_addr  (chunk_addr),
        .color_out   (color_out),
        .layer_out   (layer_out),
        .busy        (busy),
        .all_finish  (all_finish),
        .error       (error)
    );

    always #5 clk = ~clk;

    localparam int TIMEOUT = 1023;

    // e_x/e_len/e_addr are packed with chunk 0 in the rightmost slot.
    typedef struct packed {
        logic [47:0]       coords;
        logic [23:0]       col;
        logic              lay;
        int                dly;
        int                e_rows;
        int                e_fills;
        logic [2:0][11:0]  e_x;
        logic [2:0][6:0]   e_len;
        logic [2:0][23:0]  e_addr;
        logic              e_err;
    } vec_t;

    vec_t vecs[7];

    int n_tests = 0;
    int n_fail  = 0;

    int          n_math, n_row, n_fill, n_ready_bad, gap;
    bit          fin;
    logic        r_err;
    logic [23:0] r_col;
    logic        r_lay;
    logic [11:0] fx[4];
    logic [6:0]  flen[4];
    logic [23:0] faddr[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives one command and services fill_done; dly<0 means fill_done never comes.
    task automatic run_cmd(input vec_t v, input bit hold, input bit early);
        int done_at;
        int last_fs;
        n_math = 0; n_row = 0; n_fill = 0; n_ready_bad = 0; gap = -1;
        fin = 0; r_err = 1'bx; r_col = 'x; r_lay = 1'bx;
        done_at = -1; last_fs = 0;
        @(negedge clk);
        cmd_valid   = 1'b1;
        coordinates = v.coords;
        color_code  = v.col;
        layer_num   = v.lay;
        for (int t = 0; t < 5000 && !fin; t++) begin
            @(negedge clk);
            if (!hold) cmd_valid = 1'b0;
            if (math_start) n_math++;
            if (row_start) n_row++;
            if (busy && cmd_ready) n_ready_bad++;
            if (fill_start) begin
                if (n_fill < 4) begin
                    fx[n_fill]    = chunk_x;
                    flen[n_fill]  = chunk_len;
                    faddr[n_fill] = chunk_addr;
                end
                n_fill++;
                last_fs = t;
                if (v.dly >= 0) done_at = t + v.dly;
            end
            if (all_finish) begin
                fin   = 1;
                gap   = t - last_fs;
                r_err = error;
                r_col = color_out;
                r_lay = layer_out;
            end
            fill_done = (early && fill_start) || (t == done_at);
        end
        fill_done = 1'b0;
    endtask

    task automatic run_vec(input string nm, input vec_t v, input bit hold, input bit early);
        run_cmd(v, hold, early);
        check({nm, "_finish"}, 32'(fin), 32'd1);
        check({nm, "_math_cnt"}, n_math, 1);
        check({nm, "_row_cnt"}, n_row, v.e_rows);
        check({nm, "_fill_cnt"}, n_fill, v.e_fills);
        check({nm, "_ready_while_busy"}, n_ready_bad, 0);
        for (int k = 0; k < 3; k++) begin
            if (k < v.e_fills) begin
                check($sformatf("%s_x%0d", nm, k), 32'(fx[k]), 32'(v.e_x[k]));
                check($sformatf("%s_len%0d", nm, k), 32'(flen[k]), 32'(v.e_len[k]));
                check($sformatf("%s_addr%0d", nm, k), 32'(faddr[k]), 32'(v.e_addr[k]));
            end
        end
        check({nm, "_gap"}, gap, (v.dly < 0) ? TIMEOUT + 1 : v.dly + 1);
        check({nm, "_error"}, 32'(r_err), 32'(v.e_err));
        check({nm, "_color"}, 32'(r_col), 32'(v.col));
        check({nm, "_layer"}, 32'(r_lay), 32'(v.lay));
        if (!hold) begin
            @(negedge clk);
            check({nm, "_idle_busy"}, 32'(busy), 32'd0);
            check({nm, "_idle_ready"}, 32'(cmd_ready), 32'd1);
            check({nm, "_idle_error"}, 32'(error), 32'(v.e_err));
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_ready"}, 32'(cmd_ready), 32'd1);
        check({nm, "_busy"}, 32'(busy), 32'd0);
        check({nm, "_pulses"}, {28'd0, math_start, row_start, fill_start, all_finish}, 32'd0);
        check({nm, "_error"}, 32'(error), 32'd0);
        check({nm, "_chunk"}, {chunk_len, chunk_addr}, 32'd0);
        check({nm, "_row_x"}, {8'd0, cur_row, chunk_x}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t hs;
        int   t;

        vecs[0] = '{coords: 48'h000_000_03F_001, col: 24'h123456, lay: 1'b0, dly: 5,
                    e_rows: 2, e_fills: 2,
                    e_x: {12'd0, 12'd0, 12'd0}, e_len: {7'd0, 7'd64, 7'd64},
                    e_addr: {24'h0, 24'h000280, 24'h000000}, e_err: 1'b0};
        vecs[1] = '{coords: 48'h096_00A_000_00A, col: 24'hABCDEF, lay: 1'b1, dly: 2,
                    e_rows: 1, e_fills: 3,
                    e_x: {12'd128, 12'd64, 12'd0}, e_len: {7'd23, 7'd64, 7'd64},
                    e_addr: {24'h801980, 24'h801940, 24'h801900}, e_err: 1'b0};
        vecs[2] = '{coords: 48'h005_005_005_005, col: 24'hFF0000, lay: 1'b0, dly: 1,
                    e_rows: 1, e_fills: 1,
                    e_x: {12'd0, 12'd0, 12'd5}, e_len: {7'd0, 7'd0, 7'd1},
                    e_addr: {24'h0, 24'h0, 24'h000C85}, e_err: 1'b0};
        vecs[3] = '{coords: 48'h010_020_010_020, col: 24'h00FF00, lay: 1'b0, dly: -1,
                    e_rows: 1, e_fills: 1,
                    e_x: {12'd0, 12'd0, 12'd16}, e_len: {7'd0, 7'd0, 7'd1},
                    e_addr: {24'h0, 24'h0, 24'h005010}, e_err: 1'b1};
        vecs[4] = '{coords: 48'h00A_004_00A_002, col: 24'h0000FF, lay: 1'b0, dly: 3,
                    e_rows: 3, e_fills: 3,
                    e_x: {12'd10, 12'd10, 12'd10}, e_len: {7'd1, 7'd1, 7'd1},
                    e_addr: {24'h000A0A, 24'h00078A, 24'h00050A}, e_err: 1'b0};
        vecs[5] = '{coords: 48'h07F_001_000_001, col: 24'h5A5A5A, lay: 1'b0, dly: 4,
                    e_rows: 1, e_fills: 2,
                    e_x: {12'd0, 12'd64, 12'd0}, e_len: {7'd0, 7'd64, 7'd64},
                    e_addr: {24'h0, 24'h0002C0, 24'h000280}, e_err: 1'b0};
        vecs[6] = '{coords: 48'hFC0_FFF_FFF_FFF, col: 24'hC0FFEE, lay: 1'b1, dly: 2,
                    e_rows: 1, e_fills: 1,
                    e_x: {12'd0, 12'd0, 12'd4032}, e_len: {7'd0, 7'd0, 7'd64},
                    e_addr: {24'h0, 24'h0, 24'hA80D40}, e_err: 1'b0};

        rst         = 1'b1;
        cmd_valid   = 1'b0;
        coordinates = '0;
        color_code  = '0;
        layer_num   = 1'b0;
        fill_done   = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i], 1'b0, 1'b0);
        end

        // Reset while waiting for fill_done must abort at once, without a clock.
        @(negedge clk);
        cmd_valid   = 1'b1;
        coordinates = 48'h000_000_0FF_003;
        color_code  = 24'h777777;
        layer_num   = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        t = 0;
        while (!fill_start && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("rstwait_reached_fill", 32'(fill_start), 32'd1);
        repeat (3) @(negedge clk);
        check("rstwait_busy_before", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("rstwait");
        check("rstwait_color", 32'(color_out), 32'd0);
        @(negedge clk);
        check("rstwait_no_finish", 32'(all_finish), 32'd0);
        rst = 1'b0;
        run_vec("after_rst", vecs[0], 1'b0, 1'b0);

        // cmd_valid held high throughout; an early fill_done during FILL must be ignored.
        hs = vecs[2];
        hs.dly = 3;
        run_vec("hs_first", hs, 1'b1, 1'b1);
        run_vec("hs_second", vecs[5], 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
